bcd2bin_seq: RTL and testbench

//   Sequential BCD-to-binary converter (reverse double-dabble, shift-right/subtract-3).

---
 rtl/bcd2bin_seq.sv | 123 ++++++++++++
 tb/tb_bcd2bin_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3).
// One conversion per start request; the result appears BIN_W clocks after the request, with a one-cycle done pulse.
module bcd2bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [4*DIGITS-1:0]   i_bcd,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [BIN_W-1:0]      o_bin
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t             state_reg,  state_next;
   logic [BCD_W-1:0]   digit_reg,  digit_next;
   logic [BIN_W-1:0]   result_reg, result_next;
   logic [CNT_W-1:0]   count_reg,  count_next;
   logic [BIN_W-1:0]   bin_reg,    bin_next;
   logic               err_reg,    err_next;
   logic               done_reg,   done_next;

   logic [DIGITS-1:0]  digit_bad;
   logic [BCD_W-1:0]   shifted_d;
   logic [BCD_W-1:0]   corrected_d;
   logic [BIN_W-1:0]   shifted_r;

   // The concatenation {D,R} moves right by one; D's LSB becomes R's MSB.
   assign shifted_d = {1'b0, digit_reg[BCD_W-1:1]};
   assign shifted_r = {digit_reg[0], result_reg[BIN_W-1:1]};

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         // A digit code of 1010..1111 is not valid BCD.
         assign digit_bad[gi] = i_bcd[4*gi+3] & (i_bcd[4*gi+2] | i_bcd[4*gi+1]);

         // A post-shift digit of 8 or more carried a "ten" in from above: it must become 5.
         assign corrected_d[4*gi +: 4] = (shifted_d[4*gi +: 4] >= 4'd8)
                                       ? (shifted_d[4*gi +: 4] - 4'd3)
                                       :  shifted_d[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      digit_next  = digit_reg;
      result_next = result_reg;
      count_next  = count_reg;
      bin_next    = bin_reg;
      err_next    = err_reg;
      done_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (i_start) begin
               digit_next  = i_bcd;
               result_next = '0;
               count_next  = CNT_W'(BIN_W);
               if (|digit_bad) begin
                  // Malformed input completes immediately without entering BUSY.
                  err_next  = 1'b1;
                  bin_next  = '0;
                  done_next = 1'b1;
               end else begin
                  err_next   = 1'b0;
                  state_next = BUSY;
               end
            end
         end

         BUSY: begin
            digit_next  = corrected_d;
            result_next = shifted_r;
            count_next  = count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) begin
               bin_next   = shifted_r;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg  <= IDLE;
         digit_reg  <= '0;
         result_reg <= '0;
         count_reg  <= '0;
         bin_reg    <= '0;
         err_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         digit_reg  <= digit_next;
         result_reg <= result_next;
         count_reg  <= count_next;
         bin_reg    <= bin_next;
         err_reg    <= err_next;
         done_reg   <= done_next;
      end
   end

   assign o_busy = (state_reg == BUSY);
   assign o_done = done_reg;
   assign o_err  = err_reg;
   assign o_bin  = bin_reg;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: reset, single conversion, full 000..999 back-to-back sweep,
// invalid digits, start while busy, and reset during and coincident with a start.
module tb_bcd2bin_seq;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [11:0] i_bcd;
   logic        o_busy;
   logic        o_done;
   logic        o_err;
   logic [9:0]  o_bin;

   int errors = 0;
   int checks = 0;

   bcd2bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_bcd   (i_bcd),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_err   (o_err),
      .o_bin   (o_bin)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[3:0]  = 4'(v % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[11:8] = 4'((v / 100) % 10);
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_conv(input logic [11:0] bcd);
      i_start = 1'b1;
      i_bcd   = bcd;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   // Counts busy samples until o_done is seen; returns at the negedge where o_done is high.
   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (o_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (o_busy === 1'b1) busy_cycles++;
         @(negedge i_clk);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b0; i_bcd = '0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      checks++;
      if ({o_busy, o_done, o_err} !== 3'b000 || o_bin !== 10'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b err=%b bin=%0d, want all 0", o_busy, o_done, o_err, o_bin);
      end
      @(negedge i_clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b done=%b, want 0 0", o_busy, o_done);
      end
      $display("reset: busy=%b done=%b err=%b bin=%0d", o_busy, o_done, o_err, o_bin);
   endtask

   task automatic test_single();
      int bc;
      bit seen;
      start_conv(12'h042);
      checks++;
      if (o_busy !== 1'b1 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL single_start: busy=%b err=%b, want 1 0", o_busy, o_err);
      end
      wait_done(bc, seen);
      checks++;
      if (!seen || bc != 10) begin
         errors++;
         $display("FAIL single_latency: seen=%0d busy_cycles=%0d, want 1 10", seen, bc);
      end
      checks++;
      if (o_bin !== 10'd42 || o_err !== 1'b0) begin
         errors++;
         $display("FAIL single_result: bin=%0d err=%b, want 42 0", o_bin, o_err);
      end
      $display("single: bcd=042 bin=%0d err=%b busy_cycles=%0d", o_bin, o_err, bc);
      @(negedge i_clk);
      checks++;
      if (o_done !== 1'b0 || o_bin !== 10'd42) begin
         errors++;
         $display("FAIL single_pulse: done=%b bin=%0d, want 0 42", o_done, o_bin);
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      bit seen;
      int bad = 0;
      i_start = 1'b1;
      i_bcd   = to_bcd(0);
      for (int v = 0; v < 1000; v++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         i_start = 1'b0;
         wait_done(bc, seen);
         checks++;
         if (!seen || bc != 10) begin
            errors++; bad++;
            $display("FAIL sweep_latency: value=%0d seen=%0d busy_cycles=%0d, want 1 10", v, seen, bc);
         end
         checks++;
         if (o_bin !== 10'(v) || o_err !== 1'b0) begin
            errors++; bad++;
            $display("FAIL sweep_result: value=%0d bin=%0d err=%b, want %0d 0", v, o_bin, o_err, v);
         end
         if (v < 999) begin
            // Start the next conversion in the very cycle o_done is high.
            i_start = 1'b1;
            i_bcd   = to_bcd(v + 1);
         end
      end
      $display("sweep: 000..999 back-to-back, %0d bad", bad);
   endtask

   task automatic test_error();
      bit busy_seen = 1'b0;
      @(negedge i_clk);
      start_conv(12'h1A5);
      checks++;
      if (o_done !== 1'b1 || o_err !== 1'b1 || o_bin !== 10'd0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL error_complete: done=%b err=%b bin=%0d busy=%b, want 1 1 0 0", o_done, o_err, o_bin, o_busy);
      end
      $display("error: bcd=1A5 done=%b err=%b bin=%0d", o_done, o_err, o_bin);
      for (int c = 0; c < 4; c++) begin
         @(negedge i_clk);
         if (o_busy !== 1'b0) busy_seen = 1'b1;
      end
      checks++;
      if (busy_seen || o_done !== 1'b0 || o_err !== 1'b1 || o_bin !== 10'd0) begin
         errors++;
         $display("FAIL error_hold: busy_seen=%0d done=%b err=%b bin=%0d, want 0 0 1 0", busy_seen, o_done, o_err, o_bin);
      end
   endtask

   task automatic test_start_while_busy();
      int dones = 0;
      logic [9:0] got = '0;
      start_conv(12'h999);
      checks++;
      if (o_err !== 1'b0 || o_bin !== 10'd0 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_start: err=%b bin=%0d busy=%b, want 0 0 1", o_err, o_bin, o_busy);
      end
      repeat (3) @(negedge i_clk);
      i_start = 1'b1;
      i_bcd   = 12'h123;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int c = 0; c < 25; c++) begin
         if (o_done === 1'b1) begin
            dones++;
            got = o_bin;
         end
         @(negedge i_clk);
      end
      checks++;
      if (dones != 1 || got !== 10'd999) begin
         errors++;
         $display("FAIL busy_ignore: dones=%0d bin=%0d, want 1 999", dones, got);
      end
      checks++;
      if (o_busy !== 1'b0 || o_bin !== 10'd999) begin
         errors++;
         $display("FAIL busy_settle: busy=%b bin=%0d, want 0 999", o_busy, o_bin);
      end
      $display("start_while_busy: bcd=999 (123 ignored) dones=%0d bin=%0d", dones, got);
   endtask

   task automatic test_reset_abort();
      int dones = 0;
      int bc;
      bit seen;
      start_conv(12'h500);
      repeat (4) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      checks++;
      if ({o_busy, o_done, o_err} !== 3'b000 || o_bin !== 10'd0) begin
         errors++;
         $display("FAIL abort_outputs: busy=%b done=%b err=%b bin=%0d, want all 0", o_busy, o_done, o_err, o_bin);
      end
      for (int c = 0; c < 15; c++) begin
         if (o_done === 1'b1 || o_busy === 1'b1) dones++;
         @(negedge i_clk);
      end
      checks++;
      if (dones != 0 || o_bin !== 10'd0) begin
         errors++;
         $display("FAIL abort_quiet: activity=%0d bin=%0d, want 0 0", dones, o_bin);
      end
      $display("reset_abort: bcd=500 aborted, bin=%0d", o_bin);
      // Reset coincident with a start request must win.
      i_rst = 1'b1; i_start = 1'b1; i_bcd = 12'h042;
      @(negedge i_clk);
      i_rst = 1'b0; i_start = 1'b0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         if (o_done === 1'b1 || o_busy === 1'b1) dones++;
         @(negedge i_clk);
      end
      checks++;
      if (dones != 0 || o_bin !== 10'd0) begin
         errors++;
         $display("FAIL reset_wins: activity=%0d bin=%0d, want 0 0", dones, o_bin);
      end
      $display("reset_with_start: activity=%0d", dones);
      start_conv(12'h123);
      wait_done(bc, seen);
      checks++;
      if (!seen || bc != 10 || o_bin !== 10'd123) begin
         errors++;
         $display("FAIL recover: seen=%0d busy_cycles=%0d bin=%0d, want 1 10 123", seen, bc, o_bin);
      end
      $display("recover: bcd=123 bin=%0d", o_bin);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_error();
      test_start_while_busy();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
